// File: rtl/song_pkg.sv
// Shared types, field widths and the pitch lookup for the note sequencer.
package song_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_GAP
  } state_e;

  localparam int PITCH_W = 5;
  localparam int DUR_W   = 11;
  localparam int HP_W    = 15;

  localparam logic [PITCH_W-1:0] PITCH_REST = 5'd0;
  localparam logic [PITCH_W-1:0] PITCH_END  = 5'd31;

  // Half-period counts for a 25 MHz clock, semitone steps upward from A4 (440 Hz).
  function automatic logic [HP_W-1:0] pitch_to_half_period(input logic [PITCH_W-1:0] pitch);
    logic [HP_W-1:0] hp;
    case (pitch)
      5'd1:  hp = 15'd28408;
      5'd2:  hp = 15'd26814;
      5'd3:  hp = 15'd25309;
      5'd4:  hp = 15'd23889;
      5'd5:  hp = 15'd22548;
      5'd6:  hp = 15'd21283;
      5'd7:  hp = 15'd20088;
      5'd8:  hp = 15'd18961;
      5'd9:  hp = 15'd17897;
      5'd10: hp = 15'd16892;
      5'd11: hp = 15'd15944;
      5'd12: hp = 15'd15049;
      5'd13: hp = 15'd14204;
      5'd14: hp = 15'd13406;
      5'd15: hp = 15'd12654;
      5'd16: hp = 15'd11944;
      5'd17: hp = 15'd11274;
      5'd18: hp = 15'd10641;
      5'd19: hp = 15'd10044;
      5'd20: hp = 15'd9480;
      5'd21: hp = 15'd8948;
      5'd22: hp = 15'd8446;
      5'd23: hp = 15'd7972;
      5'd24: hp = 15'd7524;
      5'd25: hp = 15'd7102;
      5'd26: hp = 15'd6703;
      5'd27: hp = 15'd6327;
      5'd28: hp = 15'd5972;
      5'd29: hp = 15'd5637;
      5'd30: hp = 15'd5320;
      default: hp = '0;
    endcase
    return hp;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: output toggles every half_period+1 enabled cycles.
module tone_gen
  import song_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [HP_W-1:0] half_period,
  output logic            speaker
);

  logic [HP_W-1:0] cnt_q, cnt_d;
  logic            spk_q, spk_d;

  // Count while enabled; clear and silence as soon as enable drops.
  always_comb begin
    cnt_d = cnt_q;
    spk_d = spk_q;
    if (!en) begin
      cnt_d = '0;
      spk_d = 1'b0;
    end else if (cnt_q == half_period) begin
      cnt_d = '0;
      spk_d = ~spk_q;
    end else begin
      cnt_d = cnt_q + 15'd1;
    end
  end

  // Counter and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      spk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      spk_q <= spk_d;
    end
  end

  // Gating makes the pin go quiet in the same cycle the enable falls.
  assign speaker = spk_q & en;

endmodule

// File: rtl/note_sequencer.sv
// Steps through a note ROM, holding each pitch for its duration in ticks.
// HP_SHIFT right-shifts the half-period table so audible tones can be
// compressed into short simulations; leave at 0 on hardware.
module note_sequencer
  import song_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int TICK_DIV  = 25000,
  parameter int GAP_TICKS = 10,
  parameter int HP_SHIFT  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              stop,
  input  logic              loop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              speaker,
  output logic              tone_en,
  output logic              busy,
  output logic [ADDR_W-1:0] note_idx
);

  localparam int                TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [DUR_W-1:0]  GAP_LEN   = DUR_W'(GAP_TICKS);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [PITCH_W-1:0] pitch_q, pitch_d;
  logic [HP_W-1:0]    hp_q, hp_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [DUR_W-1:0]   dur_q, dur_d;

  logic [PITCH_W-1:0] rom_pitch;
  logic [DUR_W-1:0]   rom_dur;
  logic               tick_wrap;
  logic               cnt_done;

  assign rom_pitch = rom_data[15:11];
  assign rom_dur   = rom_data[10:0];
  assign tick_wrap = (tick_q == TICK_LAST);
  assign cnt_done  = tick_wrap && (dur_q == DUR_W'(1));

  // Sequencer next-state: fetch/decode, tick divider and duration countdown.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    pitch_d = pitch_q;
    hp_d    = hp_q;
    tick_d  = tick_q;
    dur_d   = dur_q;
    case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (play) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        if (rom_pitch == PITCH_END || (rom_dur == '0 && addr_q == ADDR_LAST)) begin
          addr_d  = '0;
          state_d = loop ? S_FETCH : S_IDLE;
        end else if (rom_dur == '0) begin
          addr_d  = addr_q + 1'b1;
          state_d = S_FETCH;
        end else begin
          pitch_d = rom_pitch;
          hp_d    = pitch_to_half_period(rom_pitch) >> HP_SHIFT;
          dur_d   = rom_dur;
          tick_d  = '0;
          idx_d   = addr_q;
          state_d = S_PLAY;
        end
      end
      S_PLAY, S_GAP: begin
        tick_d = tick_wrap ? '0 : tick_q + 1'b1;
        if (tick_wrap) dur_d = dur_q - 1'b1;
        if (cnt_done) begin
          if (state_q == S_PLAY && GAP_TICKS != 0) begin
            state_d = S_GAP;
            dur_d   = GAP_LEN;
            tick_d  = '0;
          end else begin
            // Last address behaves like an END marker; the increment wraps to 0.
            addr_d  = addr_q + 1'b1;
            state_d = (addr_q == ADDR_LAST && !loop) ? S_IDLE : S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (stop) begin
      state_d = S_IDLE;
      addr_d  = '0;
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      pitch_q <= '0;
      hp_q    <= '0;
      tick_q  <= '0;
      dur_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      pitch_q <= pitch_d;
      hp_q    <= hp_d;
      tick_q  <= tick_d;
      dur_q   <= dur_d;
    end
  end

  assign rom_addr = addr_q;
  assign note_idx = idx_q;
  assign busy     = (state_q != S_IDLE);
  assign tone_en  = (state_q == S_PLAY) && (pitch_q != PITCH_REST);

  tone_gen u_tone (
    .clk         (clk),
    .rst         (rst),
    .en          (tone_en),
    .half_period (hp_q),
    .speaker     (speaker)
  );

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer with TICK_DIV=4, GAP_TICKS=1, an 8-entry ROM and
// half-periods shifted down so tone periods fit in a few cycles.
module tb_note_sequencer;
  import song_pkg::*;

  localparam int AW  = 3;
  localparam int TD  = 4;
  localparam int GT  = 1;
  localparam int HPS = 14;

  logic          clk = 1'b0;
  logic          rst, play, stop, loop;
  logic [AW-1:0] rom_addr, note_idx;
  logic [15:0]   rom_data;
  logic          speaker, tone_en, busy;
  logic [15:0]   mem [8];

  int total = 0;
  int bad   = 0;

  typedef struct {
    string            name;
    logic [7:0][15:0] rom;
    int               busy_c;
    int               tone_c;
    int               spk_c;
    int               idx;
  } vec_t;

  typedef struct {
    string name;
    int    busy_c;
    int    tone_c;
    int    spk_c;
    int    idx;
  } res_t;

  vec_t vecs[6];
  res_t sb_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= mem[rom_addr];

  note_sequencer #(
    .ADDR_W(AW), .TICK_DIV(TD), .GAP_TICKS(GT), .HP_SHIFT(HPS)
  ) dut (
    .clk(clk), .rst(rst), .play(play), .stop(stop), .loop(loop),
    .rom_addr(rom_addr), .rom_data(rom_data), .speaker(speaker),
    .tone_en(tone_en), .busy(busy), .note_idx(note_idx)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] ent(input int p, input int d);
    return {5'(p), 11'(d)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the first cycle after play is sampled.
  task automatic pulse_play();
    play = 1'b1;
    @(negedge clk);
    play = 1'b0;
  endtask

  task automatic wait_tone(input logic val, input int limit, output int ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      if (tone_en === val) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_until_idle(input int limit, output int nb, output int nt,
                                output int ns, output int ok);
    nb = 0; nt = 0; ns = 0; ok = 0;
    for (int i = 0; i < limit; i++) begin
      if (busy !== 1'b1) begin
        ok = 1;
        break;
      end
      nb++;
      if (tone_en === 1'b1) nt++;
      if (speaker === 1'b1) ns++;
      @(negedge clk);
    end
  endtask

  task automatic load_end_rom();
    for (int i = 0; i < 8; i++) mem[i] = 16'hF800;
  endtask

  initial begin
    int   nb, nt, ns, ok;
    res_t r;

    rst = 1'b1; play = 1'b0; stop = 1'b0; loop = 1'b0;
    load_end_rom();

    for (int v = 0; v < 6; v++)
      for (int i = 0; i < 8; i++) vecs[v].rom[i] = 16'hF800;
    vecs[0].name = "one_note";
    vecs[0].rom[0] = ent(1, 2);
    vecs[0].busy_c = 16; vecs[0].tone_c = 8;  vecs[0].spk_c = 4;  vecs[0].idx = 0;
    vecs[1].name = "rest_then_note";
    vecs[1].rom[0] = ent(0, 3); vecs[1].rom[1] = ent(2, 1);
    vecs[1].busy_c = 30; vecs[1].tone_c = 4;  vecs[1].spk_c = 2;  vecs[1].idx = 1;
    vecs[2].name = "skip_zero_dur";
    vecs[2].rom[0] = ent(3, 0); vecs[2].rom[1] = ent(1, 1);
    vecs[2].busy_c = 14; vecs[2].tone_c = 4;  vecs[2].spk_c = 2;  vecs[2].idx = 1;
    vecs[3].name = "full_rom_no_end";
    for (int i = 0; i < 8; i++) vecs[3].rom[i] = ent(5, 1);
    vecs[3].busy_c = 80; vecs[3].tone_c = 32; vecs[3].spk_c = 16; vecs[3].idx = 7;
    vecs[4].name = "last_entry_dur0";
    for (int i = 0; i < 7; i++) vecs[4].rom[i] = ent(1, 1);
    vecs[4].rom[7] = ent(1, 0);
    vecs[4].busy_c = 72; vecs[4].tone_c = 28; vecs[4].spk_c = 14; vecs[4].idx = 6;
    vecs[5].name = "fast_pitch";
    vecs[5].rom[0] = ent(13, 3);
    vecs[5].busy_c = 20; vecs[5].tone_c = 12; vecs[5].spk_c = 6;  vecs[5].idx = 0;

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_tone", tone_en, 0);
    chk("rst_spk", speaker, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_idx", note_idx, 0);
    chk("hp_table_1", pitch_to_half_period(5'd1), 28408);

    // Start latency: FETCH, LOAD, then tone
    for (int i = 0; i < 8; i++) mem[i] = vecs[0].rom[i];
    pulse_play();
    chk("lat_fetch_busy", busy, 1);
    chk("lat_fetch_tone", tone_en, 0);
    @(negedge clk);
    chk("lat_load_tone", tone_en, 0);
    @(negedge clk);
    chk("lat_play_tone", tone_en, 1);
    run_until_idle(100, nb, nt, ns, ok);
    chk("lat_end_timeout", ok, 1);

    // Song table through the scoreboard
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 8; i++) mem[i] = vecs[v].rom[i];
      r.name = vecs[v].name;
      r.busy_c = vecs[v].busy_c; r.tone_c = vecs[v].tone_c;
      r.spk_c = vecs[v].spk_c;   r.idx = vecs[v].idx;
      sb_q.push_back(r);
      @(negedge clk);
      pulse_play();
      run_until_idle(300, nb, nt, ns, ok);
      r = sb_q.pop_front();
      chk({r.name, "_timeout"}, ok, 1);
      chk({r.name, "_busy"}, nb, r.busy_c);
      chk({r.name, "_tone"}, nt, r.tone_c);
      chk({r.name, "_spk"}, ns, r.spk_c);
      chk({r.name, "_idx"}, note_idx, r.idx);
    end

    // Reset in the middle of PLAY
    for (int i = 0; i < 8; i++) mem[i] = vecs[0].rom[i];
    @(negedge clk);
    pulse_play();
    repeat (4) @(negedge clk);
    chk("pre_rst_spk", speaker, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_spk", speaker, 0);
    chk("midrst_tone", tone_en, 0);
    chk("midrst_addr", rom_addr, 0);

    // stop together with play during PLAY
    @(negedge clk);
    pulse_play();
    repeat (4) @(negedge clk);
    chk("pre_stop_spk", speaker, 1);
    stop = 1'b1; play = 1'b1;
    @(negedge clk);
    stop = 1'b0; play = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_tone", tone_en, 0);
    chk("stop_spk", speaker, 0);
    chk("stop_addr", rom_addr, 0);
    @(negedge clk);
    chk("stop_no_restart", busy, 0);

    // Loop a one-note song, then clear loop during the replay
    load_end_rom();
    mem[0] = ent(1, 1);
    loop = 1'b1;
    @(negedge clk);
    pulse_play();
    wait_tone(1'b1, 10, ok);
    chk("loop_first_rise", ok, 1);
    wait_tone(1'b0, 10, ok);
    chk("loop_first_fall", ok, 1);
    nb = 0;
    for (int i = 0; i < 30 && tone_en !== 1'b1; i++) begin
      nb++;
      @(negedge clk);
    end
    chk("loop_silent_cycles", nb, 8);
    chk("loop_replay_addr", rom_addr, 0);
    chk("loop_replay_idx", note_idx, 0);
    loop = 1'b0;
    run_until_idle(100, nb, nt, ns, ok);
    chk("unloop_timeout", ok, 1);
    chk("unloop_busy", nb, 10);
    chk("unloop_tone", nt, 4);

    // Full ROM with loop wraps back to address 0
    for (int i = 0; i < 8; i++) mem[i] = ent(5, 1);
    loop = 1'b1;
    @(negedge clk);
    pulse_play();
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (tone_en === 1'b1 && note_idx == 3'd7) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk("wrap_reach_last", ok, 1);
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (tone_en === 1'b1 && note_idx == 3'd0) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk("wrap_replay", ok, 1);
    chk("wrap_busy", busy, 1);
    chk("wrap_addr", rom_addr, 0);
    stop = 1'b1;
    loop = 1'b0;
    @(negedge clk);
    stop = 1'b0;
    chk("wrap_stop_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
